// File: rtl/debounce_pkg.sv
// Shared types and sizing helpers for the debounce bank.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    HOLD_DELAY  = 2'd1,
    HOLD_REPEAT = 2'd2
  } rpt_state_t;

  // Counter width able to hold 0..n-1, never below one bit.
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounced channel: 2-flop synchroniser, symmetric stable-time qualifier,
// and auto-repeat FSM producing registered level/rise/fall/press.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int DB_CYCLES     = 100000000,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic clk,
  input  logic rst_ext,
  input  logic undeb,
  output logic deb,
  output logic rise,
  output logic fall,
  output logic press
);

  localparam int CW = cnt_w(DB_CYCLES);
  localparam int RW = cnt_w(max2(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  logic          s1_q, s2_q, deb_q, rise_q, fall_q, press_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rcnt_q;
  rpt_state_t    st_q;
  logic          chg, acc, acc_hi, acc_lo;

  // Any sample matching the current level discards accumulated credit.
  always_comb begin
    chg    = (s2_q != deb_q);
    acc    = chg && (cnt_q == DB_LAST);
    acc_hi = acc && s2_q;
    acc_lo = acc && !s2_q;
    cnt_d  = '0;
    if (chg && !acc) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst_ext) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      deb_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      st_q    <= IDLE;
    end else begin
      s1_q    <= undeb;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      if (acc) deb_q <= s2_q;
      rise_q  <= acc_hi;
      fall_q  <= acc_lo;
      press_q <= 1'b0;
      if (acc_lo) begin
        st_q   <= IDLE;
        rcnt_q <= '0;
      end else begin
        case (st_q)
          IDLE: begin
            if (acc_hi) begin
              press_q <= 1'b1;
              rcnt_q  <= '0;
              if (REPEAT_EN != 0) st_q <= HOLD_DELAY;
            end
          end
          HOLD_DELAY: begin
            if (rcnt_q == RD_LAST) begin
              st_q    <= HOLD_REPEAT;
              rcnt_q  <= '0;
              press_q <= 1'b1;
            end else begin
              rcnt_q <= rcnt_q + 1'b1;
            end
          end
          HOLD_REPEAT: begin
            if (rcnt_q == RP_LAST) begin
              rcnt_q  <= '0;
              press_q <= 1'b1;
            end else begin
              rcnt_q <= rcnt_q + 1'b1;
            end
          end
          default: begin
            st_q   <= IDLE;
            rcnt_q <= '0;
          end
        endcase
      end
    end
  end

  assign deb   = deb_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign press = press_q;

endmodule

// File: rtl/debounce_bank.sv
// N_CH independent debounced key channels plus a lowest-index press encoder
// so the consumer sees at most one key event per clock.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int DB_CYCLES     = 100000000,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic                     clk,
  input  logic                     rst_ext,
  input  logic [N_CH-1:0]          undeb,
  output logic [N_CH-1:0]          deb,
  output logic [N_CH-1:0]          rise,
  output logic [N_CH-1:0]          fall,
  output logic [N_CH-1:0]          press,
  output logic                     any_press,
  output logic [cnt_w(N_CH)-1:0]   press_idx
);

  localparam int IW = cnt_w(N_CH);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_chan #(
      .DB_CYCLES    (DB_CYCLES),
      .REPEAT_EN    (REPEAT_EN),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_chan (
      .clk    (clk),
      .rst_ext(rst_ext),
      .undeb  (undeb[g]),
      .deb    (deb[g]),
      .rise   (rise[g]),
      .fall   (fall[g]),
      .press  (press[g])
    );
  end

  // Scan high to low so the lowest pressed index wins.
  always_comb begin
    any_press = |press;
    press_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (press[i]) press_idx = IW'(i);
    end
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed plus randomized checks of two debounce_bank builds (repeat on/off)
// against a run-length / press-age reference model.
module tb_debounce_bank;
  localparam int N = 4, DB = 4, RD = 10, RP = 3;

  logic clk = 1'b0;
  logic rst_ext;
  logic [N-1:0] undeb;
  logic [N-1:0] deb_a, rise_a, fall_a, press_a, deb_b, rise_b, fall_b, press_b;
  logic any_a, any_b;
  logic [1:0] idx_a, idx_b;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  debounce_bank #(.N_CH(N), .DB_CYCLES(DB), .REPEAT_EN(1), .REPEAT_DELAY(RD),
                  .REPEAT_PERIOD(RP)) dut_a (
    .clk(clk), .rst_ext(rst_ext), .undeb(undeb), .deb(deb_a), .rise(rise_a),
    .fall(fall_a), .press(press_a), .any_press(any_a), .press_idx(idx_a));

  debounce_bank #(.N_CH(N), .DB_CYCLES(DB), .REPEAT_EN(0), .REPEAT_DELAY(RD),
                  .REPEAT_PERIOD(RP)) dut_b (
    .clk(clk), .rst_ext(rst_ext), .undeb(undeb), .deb(deb_b), .rise(rise_b),
    .fall(fall_b), .press(press_b), .any_press(any_b), .press_idx(idx_b));

  // Model: index 0 = repeat build, 1 = no-repeat build.
  logic [N-1:0] m_s1[2], m_s2[2], m_deb[2], m_rise[2], m_fall[2], m_press[2];
  int m_run[2][N], m_age[2][N];
  bit m_held[2][N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] low_idx(input logic [N-1:0] p);
    for (int i = 0; i < N; i++) if (p[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (rst_ext) begin
        m_s1[d] = '0; m_s2[d] = '0; m_deb[d] = '0;
        m_rise[d] = '0; m_fall[d] = '0; m_press[d] = '0;
        for (int c = 0; c < N; c++) begin
          m_run[d][c] = 0; m_age[d][c] = 0; m_held[d][c] = 0;
        end
      end else begin
        for (int c = 0; c < N; c++) begin
          bit acc = 0;
          m_rise[d][c] = 0; m_fall[d][c] = 0; m_press[d][c] = 0;
          if (m_s2[d][c] != m_deb[d][c]) begin
            m_run[d][c]++;
            if (m_run[d][c] == DB) begin
              acc = 1; m_deb[d][c] = m_s2[d][c]; m_run[d][c] = 0;
            end
          end else m_run[d][c] = 0;
          if (acc && m_deb[d][c]) begin
            m_rise[d][c] = 1; m_press[d][c] = 1; m_held[d][c] = 1; m_age[d][c] = 0;
          end else if (acc) begin
            m_fall[d][c] = 1; m_held[d][c] = 0;
          end else if (m_held[d][c]) begin
            m_age[d][c]++;
            if (d == 0 && m_age[d][c] >= RD && (m_age[d][c] - RD) % RP == 0)
              m_press[d][c] = 1;
          end
          m_s2[d][c] = m_s1[d][c];
          m_s1[d][c] = undeb[c];
        end
      end
    end
  endtask

  task automatic check_all();
    chk("deb_a", deb_a, m_deb[0]);     chk("rise_a", rise_a, m_rise[0]);
    chk("fall_a", fall_a, m_fall[0]);  chk("press_a", press_a, m_press[0]);
    chk("any_a", any_a, |m_press[0]);  chk("idx_a", idx_a, low_idx(m_press[0]));
    chk("deb_b", deb_b, m_deb[1]);     chk("rise_b", rise_b, m_rise[1]);
    chk("fall_b", fall_b, m_fall[1]);  chk("press_b", press_b, m_press[1]);
    chk("any_b", any_b, |m_press[1]);  chk("idx_b", idx_b, low_idx(m_press[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    int n, np, nco;
    bit strobe1;
    int offs[$];
    int exp_offs[8] = '{0, 10, 13, 16, 19, 22, 25, 28};

    rst_ext = 1'b1; undeb = '0;
    tick(); tick();
    chk("reset_deb", deb_a, 4'h0);
    chk("reset_press", press_a, 4'h0);
    chk("reset_idx", idx_a, 2'd0);
    rst_ext = 1'b0;
    tick(); tick();

    // Basic acceptance latency on channel 0
    undeb[0] = 1'b1;
    repeat (5) tick();
    chk("t1_not_yet", deb_a[0], 1'b0);
    tick();
    chk("t1_deb", deb_a[0], 1'b1);
    chk("t1_rise", rise_a[0], 1'b1);
    chk("t1_press", press_a[0], 1'b1);
    tick();
    chk("t1_rise_single", rise_a[0], 1'b0);

    // Bounce channel 1: never 4 consecutive differing samples
    strobe1 = 0;
    for (int r = 0; r < 5; r++) begin
      undeb[1] = 1'b1;
      for (int k = 0; k < 3; k++) begin tick(); strobe1 |= rise_a[1] | fall_a[1]; end
      undeb[1] = 1'b0;
      tick(); strobe1 |= rise_a[1] | fall_a[1];
    end
    repeat (4) begin tick(); strobe1 |= rise_a[1] | fall_a[1]; end
    chk("t2_deb1", deb_a[1], 1'b0);
    chk("t2_strobe1", strobe1, 1'b0);

    // Auto-repeat schedule on channel 2
    undeb[2] = 1'b1;
    n = 0;
    while (!rise_a[2] && n < 20) begin tick(); n++; end
    chk("t3_rise_wait", rise_a[2], 1'b1);
    for (int off = 0; off < 30; off++) begin
      if (press_a[2]) offs.push_back(off);
      tick();
    end
    chk("t3_npress", offs.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < offs.size()) chk("t3_offset", offs[i], exp_offs[i]);
    undeb[2] = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!fall_a[2] && n < 20);
    chk("t3_fall_lat", n, 6);
    chk("t3_fall_nopress", press_a[2], 1'b0);

    // Simultaneous acceptance on channels 1 and 3
    undeb = '0;
    repeat (10) tick();
    undeb = 4'b1010;
    repeat (6) tick();
    chk("t4_press", press_a, 4'b1010);
    chk("t4_any", any_a, 1'b1);
    chk("t4_idx", idx_a, 2'd1);

    // Reset while channel 0 held high
    undeb = 4'b0001;
    repeat (10) tick();
    chk("t5_pre_deb0", deb_a[0], 1'b1);
    rst_ext = 1'b1;
    tick();
    chk("t5_rst_deb", deb_a, 4'h0);
    chk("t5_rst_strobes", {rise_a, fall_a, press_a}, 12'h0);
    chk("t5_rst_any", any_a, 1'b0);
    rst_ext = 1'b0;
    repeat (5) tick();
    chk("t5_rise_early", rise_a[0], 1'b0);
    tick();
    chk("t5_rise_again", rise_a[0], 1'b1);

    // No-repeat build: single press per hold
    undeb = '0;
    repeat (10) tick();
    undeb[0] = 1'b1;
    np = 0; nco = 0;
    repeat (40) begin
      tick();
      if (press_b[0]) np++;
      if (press_b[0] && rise_b[0]) nco++;
    end
    chk("t6_npress", np, 1);
    chk("t6_coincide", nco, 1);

    // Randomized slowly-varying inputs with rare resets
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) undeb[b] = ~undeb[b];
      rst_ext = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Multi-channel, parametrised debouncer for the calculator's push-button and key inputs. Each channel synchronises a raw asynchronous input, qualifies it with a stable-time counter in both directions, and emits the debounced level, one-cycle rise/fall strobes and an optional auto-repeat "press" strobe. A lowest-index priority encoder reports which key pressed this cycle, so the downstream calculator FSM consumes a single key event per clock.

## Interface
- `N_CH`, 4: number of independent channels (1..32).
- `DB_CYCLES`, 100000000: consecutive stable cycles required to accept a new level (≥2).
- `REPEAT_EN`, 0: 1 enables auto-repeat press strobes while held.
- `REPEAT_DELAY`, 50000000: cycles from accepted press to first repeat (≥2).
- `REPEAT_PERIOD`, 10000000: cycles between subsequent repeats (≥2).

- `clk` in 1: system clock.
- `rst_ext` in 1: reset, synchronous, active-high.
- `undeb` in N_CH: raw asynchronous inputs, active-high.
- `deb` out N_CH: debounced levels.
- `rise` out N_CH: 1-cycle strobe when `deb[i]` goes 0→1.
- `fall` out N_CH: 1-cycle strobe when `deb[i]` goes 1→0.
- `press` out N_CH: 1-cycle strobe on each rise and, if REPEAT_EN, each repeat.
- `any_press` out 1: OR of `press`.
- `press_idx` out $clog2(N_CH) (min 1): lowest index i with `press[i]`=1; 0 when none.

## Operation
- Per channel: 2-flop synchroniser (`s1`, `s2`), counter `cnt` of width $clog2(DB_CYCLES), register `deb_q`.
- Each edge: if `s2 == deb_q`, `cnt` ← 0. Else if `cnt == DB_CYCLES-1`, `deb_q` ← `s2`, `cnt` ← 0. Else `cnt` ← `cnt`+1. A single matching sample restarts qualification; there is no partial credit.
- `rise`/`fall` are registered alongside `deb_q`: high exactly in the first cycle `deb` shows the new level.
- Repeat FSM per channel (states in package): IDLE, HOLD_DELAY, HOLD_REPEAT.
  - IDLE: on acceptance of 1 → HOLD_DELAY, `rcnt` ← 0, press with the rise.
  - HOLD_DELAY: `rcnt`++; at `rcnt == REPEAT_DELAY-1` → HOLD_REPEAT, `rcnt` ← 0, press.
  - HOLD_REPEAT: `rcnt`++; at `rcnt == REPEAT_PERIOD-1` press, `rcnt` ← 0.
  - Any state: acceptance of 0 (fall) → IDLE, `rcnt` ← 0, no press that cycle.
  - REPEAT_EN=0: FSM stays IDLE after rise; `press` == `rise`.
- `rcnt` width: $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)); no wrap beyond terminal count.
- `any_press`/`press_idx` are combinational from registered `press`.
- Simultaneous presses on several channels: all `press` bits set; `press_idx` reports lowest; no event queued for others.

## Timing
- Reset: `s1`, `s2`, `deb`, `rise`, `fall`, `press`, `cnt`, `rcnt` all 0; FSM IDLE; `any_press`=0, `press_idx`=0.
- Latency: `deb` changes after the (DB_CYCLES+2)-th rising edge at which `undeb` holds the new value (2 sync + DB_CYCLES qualify).
- Pulses shorter than DB_CYCLES+? cycles at `s2` (any glitch < DB_CYCLES samples) never change `deb`.
- First repeat: REPEAT_DELAY cycles after the rise strobe; then every REPEAT_PERIOD cycles.
- Reset mid-operation: all state cleared that cycle; an input held high across reset is re-qualified and produces a fresh rise/press DB_CYCLES+2 edges after `rst_ext` deasserts.
- No input combinational path to outputs; `undeb` feeds only `s1`.

## Structure
- `debounce_pkg`: `rpt_state_t` enum (IDLE, HOLD_DELAY, HOLD_REPEAT), width helper function for counter sizing.
- Sub-module `debounce_chan`: one channel (synchroniser, qualify counter, repeat FSM); `debounce_bank` generates N_CH instances plus the priority encoder.

## Test plan
Parameters for bench: N_CH=4, DB_CYCLES=4, REPEAT_EN=1, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Hold `undeb[0]`=1 from edge k → `deb[0]`, `rise[0]`, `press[0]` high after edge k+5; `rise` single cycle.
- Bounce `undeb[1]` 1 for 3 cycles, 0 for 1, repeated 5× → `deb[1]` stays 0, no strobes.
- Hold `undeb[2]` 30 cycles after acceptance → presses at offsets 0, 10, 13, 16, 19, 22, 25, 28; release → `fall[2]` after 6 edges, no press.
- Accept `undeb[3]` and `undeb[1]` on the same edge → `press`=4'b1010, `any_press`=1, `press_idx`=1.
- Assert `rst_ext` one cycle while `deb[0]`=1 and `undeb[0]` held → all outputs 0 next cycle; `rise[0]` again 6 edges after deassert.
- REPEAT_EN=0 build, hold 40 cycles → exactly one `press`, coincident with `rise`.
